// File: rtl/arbitro_mux2a1.sv
// Round-robin arbiter for two requesters sharing one 2:1 mux channel,
// with bounded bursts and a one-entry registered valid/ready output stage.
module arbitro_mux2a1 #(
    parameter int ANCHO      = 8,
    parameter int MAX_RAFAGA = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             solicitud_x,
    input  logic [ANCHO-1:0] dato_x,
    output logic             listo_x,
    input  logic             solicitud_y,
    input  logic [ANCHO-1:0] dato_y,
    output logic             listo_y,
    output logic             selector,
    output logic [1:0]       concesion,
    output logic [ANCHO-1:0] salida,
    output logic             salida_valida,
    input  logic             salida_listo
);

    typedef enum logic [1:0] {
        LIBRE,
        SERVIR_X,
        SERVIR_Y
    } estado_t;

    localparam logic [7:0] TOPE = 8'(MAX_RAFAGA - 1);

    estado_t    estado, estado_sig;
    logic [7:0] cuenta, cuenta_sig;
    logic       ultimo, ultimo_sig;
    logic       libre_sal;
    logic       tx_x, tx_y;

    assign libre_sal = !salida_valida || salida_listo;
    assign listo_x   = (estado == SERVIR_X) && libre_sal;
    assign listo_y   = (estado == SERVIR_Y) && libre_sal;
    assign tx_x      = listo_x && solicitud_x;
    assign tx_y      = listo_y && solicitud_y;
    assign concesion = {estado == SERVIR_Y, estado == SERVIR_X};

    always_comb begin
        estado_sig = estado;
        cuenta_sig = cuenta;
        ultimo_sig = ultimo;
        unique case (estado)
            LIBRE: begin
                if (solicitud_x && solicitud_y)
                    estado_sig = ultimo ? SERVIR_X : SERVIR_Y;
                else if (solicitud_x)
                    estado_sig = SERVIR_X;
                else if (solicitud_y)
                    estado_sig = SERVIR_Y;
            end
            SERVIR_X: begin
                if (!solicitud_x) begin
                    estado_sig = solicitud_y ? SERVIR_Y : LIBRE;
                    ultimo_sig = 1'b0;
                    cuenta_sig = '0;
                end else if (tx_x) begin
                    if (cuenta == TOPE) begin
                        cuenta_sig = '0;
                        if (solicitud_y) begin
                            estado_sig = SERVIR_Y;
                            ultimo_sig = 1'b0;
                        end
                    end else begin
                        cuenta_sig = cuenta + 8'd1;
                    end
                end
            end
            SERVIR_Y: begin
                if (!solicitud_y) begin
                    estado_sig = solicitud_x ? SERVIR_X : LIBRE;
                    ultimo_sig = 1'b1;
                    cuenta_sig = '0;
                end else if (tx_y) begin
                    if (cuenta == TOPE) begin
                        cuenta_sig = '0;
                        if (solicitud_x) begin
                            estado_sig = SERVIR_X;
                            ultimo_sig = 1'b1;
                        end
                    end else begin
                        cuenta_sig = cuenta + 8'd1;
                    end
                end
            end
            default: begin
                estado_sig = LIBRE;
                cuenta_sig = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= LIBRE;
            cuenta <= '0;
            ultimo <= 1'b1;
        end else begin
            estado <= estado_sig;
            cuenta <= cuenta_sig;
            ultimo <= ultimo_sig;
        end
    end

    // selector tracks the granted side and keeps its value while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            selector <= 1'b0;
        else if (estado_sig == SERVIR_X)
            selector <= 1'b0;
        else if (estado_sig == SERVIR_Y)
            selector <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            salida        <= '0;
            salida_valida <= 1'b0;
        end else if (tx_x) begin
            salida        <= dato_x;
            salida_valida <= 1'b1;
        end else if (tx_y) begin
            salida        <= dato_y;
            salida_valida <= 1'b1;
        end else if (salida_listo) begin
            salida_valida <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arbitro_mux2a1.sv
// Bench for arbitro_mux2a1: burst-level arbitration model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_arbitro_mux2a1;

    localparam int ANCHO = 8;
    localparam int MAXR  = 4;

    logic             clk = 0;
    logic             rst_n;
    logic             solicitud_x, solicitud_y, salida_listo;
    logic [ANCHO-1:0] dato_x, dato_y;
    logic             listo_x, listo_y, selector, salida_valida;
    logic [1:0]       concesion;
    logic [ANCHO-1:0] salida;

    arbitro_mux2a1 #(.ANCHO(ANCHO), .MAX_RAFAGA(MAXR)) dut (
        .clk(clk), .rst_n(rst_n),
        .solicitud_x(solicitud_x), .dato_x(dato_x), .listo_x(listo_x),
        .solicitud_y(solicitud_y), .dato_y(dato_y), .listo_y(listo_y),
        .selector(selector), .concesion(concesion),
        .salida(salida), .salida_valida(salida_valida),
        .salida_listo(salida_listo)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // model: who holds the channel (0 none, 1 X, 2 Y), beats in burst,
    // who was served last, and the content of the output slot
    int             g, beats, last;
    bit             m_sel, ov;
    logic [ANCHO-1:0] od;

    always @(posedge clk or negedge rst_n) begin
        bit free, ack, mine, other;
        if (!rst_n) begin
            g = 0; beats = 0; last = 2; m_sel = 0; ov = 0; od = '0;
        end else begin
            free  = !ov || salida_listo;
            ack   = free && ((g == 1 && solicitud_x) ||
                             (g == 2 && solicitud_y));
            if (ack) begin
                ov = 1;
                od = (g == 1) ? dato_x : dato_y;
            end else if (salida_listo) begin
                ov = 0;
            end
            if (g == 0) begin
                if (solicitud_x && solicitud_y) g = (last == 2) ? 1 : 2;
                else if (solicitud_x) g = 1;
                else if (solicitud_y) g = 2;
            end else begin
                mine  = (g == 1) ? solicitud_x : solicitud_y;
                other = (g == 1) ? solicitud_y : solicitud_x;
                if (!mine) begin
                    last = g; beats = 0;
                    g = other ? 3 - g : 0;
                end else if (ack) begin
                    beats++;
                    if (beats == MAXR) begin
                        beats = 0;
                        if (other) begin
                            last = g; g = 3 - g;
                        end
                    end
                end
            end
            if (g == 1) m_sel = 0;
            else if (g == 2) m_sel = 1;
        end
    end

    bit               cap = 0;
    logic [ANCHO-1:0] q[$];

    always @(negedge clk) begin
        bit free;
        free = !ov || salida_listo;
        chk("concesion", 32'(concesion),
            32'((g == 1) ? 2'b01 : (g == 2) ? 2'b10 : 2'b00));
        chk("listo_x", 32'(listo_x), 32'(g == 1 && free));
        chk("listo_y", 32'(listo_y), 32'(g == 2 && free));
        chk("selector", 32'(selector), 32'(m_sel));
        chk("salida_valida", 32'(salida_valida), 32'(ov));
        chk("salida", 32'(salida), 32'(od));
        if (cap && rst_n && salida_valida && salida_listo)
            q.push_back(salida);
    end

    task automatic cyc();
        bit tx, ty;
        @(negedge clk);
        tx = listo_x && solicitud_x;
        ty = listo_y && solicitud_y;
        @(posedge clk);
        #1;
        if (tx) dato_x++;
        if (ty) dato_y++;
    endtask

    logic [ANCHO-1:0] exp_seq [9] = '{8'h10, 8'h11, 8'h12, 8'h13,
        8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h14};

    initial begin
        rst_n = 0;
        solicitud_x = 1'($urandom); solicitud_y = 1'($urandom);
        dato_x = 8'($urandom); dato_y = 8'($urandom);
        salida_listo = 1'($urandom);
        repeat (3) cyc();
        chk("rst_concesion", 32'(concesion), 0);
        chk("rst_valida", 32'(salida_valida), 0);
        chk("rst_salida", 32'(salida), 0);

        solicitud_x = 1; solicitud_y = 1; salida_listo = 1;
        dato_x = 8'h10; dato_y = 8'hA0; cap = 1; rst_n = 1;
        cyc();
        chk("tie_grant_x", 32'(concesion), 32'h1);
        chk("tie_listo_x", 32'(listo_x), 1);
        repeat (10) cyc();
        cap = 0;
        chk("seq_len_ok", 32'(q.size() >= 9), 1);
        for (int i = 0; i < 9; i++)
            if (i < q.size()) chk("rr_seq", 32'(q[i]), 32'(exp_seq[i]));

        solicitud_y = 0;
        repeat (8) cyc();
        chk("xonly_grant", 32'(concesion), 32'h1);

        salida_listo = 0;
        repeat (3) cyc();
        chk("bp_listo_x", 32'(listo_x), 0);
        chk("bp_valida", 32'(salida_valida), 1);
        salida_listo = 1;
        cyc();

        solicitud_x = 0; solicitud_y = 1;
        cyc();
        chk("switch_y", 32'(concesion), 32'h2);
        solicitud_x = 1;
        repeat (2) cyc();
        solicitud_y = 0;
        cyc();
        chk("release_to_x", 32'(concesion), 32'h1);
        chk("release_sel", 32'(selector), 0);

        solicitud_y = 1;
        repeat (2) cyc();
        #2 rst_n = 0;
        #1;
        chk("async_concesion", 32'(concesion), 0);
        chk("async_valida", 32'(salida_valida), 0);
        chk("async_salida", 32'(salida), 0);
        chk("async_listo_x", 32'(listo_x), 0);
        chk("async_selector", 32'(selector), 0);
        repeat (2) cyc();
        rst_n = 1;
        cyc();
        chk("tie_again_x", 32'(concesion), 32'h1);
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
